// File: rtl/tl_grant_arbiter.sv
// Round-robin arbiter merging tracker grants onto one inner grant channel.
// A multi-beat grant locks the channel to its owner until the last beat fires.

module tl_grant_lane #(
  parameter int GNT_W = 128
) (
  input  logic             hit,
  input  logic             grant_valid,
  input  logic             grant_ready,
  input  logic [GNT_W-1:0] bits,
  output logic             ready,
  output logic [GNT_W-1:0] bits_masked
);
  assign ready       = hit & grant_valid & grant_ready;
  assign bits_masked = hit ? bits : '0;
endmodule

module tl_grant_arbiter #(
  parameter int N_REQ = 4,
  parameter int GNT_W = 128,
  parameter int BEATS = 4,
  localparam int SEL_W = $clog2(N_REQ),
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*GNT_W-1:0] req_bits,
  input  logic [N_REQ-1:0]       req_has_data,
  output logic                   grant_valid,
  input  logic                   grant_ready,
  output logic [GNT_W-1:0]       grant_bits,
  output logic [SEL_W-1:0]       grant_src,
  output logic                   lock_active,
  output logic [CNT_W-1:0]       beat_cnt
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                        state, state_nxt;
  logic [SEL_W-1:0]              owner, owner_nxt, last_win, last_win_nxt;
  logic [SEL_W-1:0]              sel, cand;
  logic [CNT_W-1:0]              beat_nxt;
  logic                          found, fire;
  logic [N_REQ-1:0]              hit;
  logic [N_REQ-1:0][GNT_W-1:0]   lane_bits, lane_masked;

  assign lane_bits = req_bits;

  // Selection: the owner while locked, else first valid after last_win.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    if (state == LOCKED) begin
      sel   = owner;
      found = 1'b1;
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = SEL_W'((int'(last_win) + k) % N_REQ);
        if (!found && req_valid[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
  end

  assign grant_valid = found & req_valid[sel];
  assign grant_src   = sel;
  assign fire        = grant_valid & grant_ready;
  assign lock_active = (state == LOCKED);

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign hit[g] = found && (sel == SEL_W'(g));
    tl_grant_lane #(.GNT_W(GNT_W)) u_lane (
      .hit         (hit[g]),
      .grant_valid (grant_valid),
      .grant_ready (grant_ready),
      .bits        (lane_bits[g]),
      .ready       (req_ready[g]),
      .bits_masked (lane_masked[g])
    );
  end

  always_comb begin
    grant_bits = '0;
    for (int i = 0; i < N_REQ; i++) grant_bits |= lane_masked[i];
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    last_win_nxt = last_win;
    beat_nxt     = beat_cnt;
    case (state)
      IDLE: if (fire) begin
        last_win_nxt = sel;
        if (req_has_data[sel] && BEATS > 1) begin
          state_nxt = LOCKED;
          owner_nxt = sel;
          beat_nxt  = CNT_W'(1);
        end
      end
      LOCKED: if (fire) begin
        if (beat_cnt == CNT_W'(BEATS - 1)) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end else begin
          beat_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last_win resets to N_REQ-1 so the first arbitration favours tracker 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      owner    <= '0;
      last_win <= SEL_W'(N_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      last_win <= last_win_nxt;
      beat_cnt <= beat_nxt;
    end
  end
endmodule

// File: doc/tl_grant_arbiter.md
TL_GRANT_ARBITER -- requirements
Module: tl_grant_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of tracker requesters sharing the inner grant channel (2..16).
REQ-002 SHALL have parameter GNT_W, default 128, meaning the width of one packed grant message (addr_beat, client_xact_id, manager_xact_id, is_builtin_type, g_type, data, client_id).
REQ-003 SHALL have parameter BEATS, default 4, meaning the number of beats in a data-carrying grant (power of 2, >=1).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, N_REQ bits: per-tracker grant valid.
REQ-008 SHALL have port req_ready, output, N_REQ bits: per-tracker grant accepted.
REQ-009 SHALL have port req_bits, input, N_REQ*GNT_W bits: packed grant messages, where tracker i occupies slice [i*GNT_W +: GNT_W].
REQ-010 SHALL have port req_has_data, input, N_REQ bits: the current grant of tracker i is multi-beat.
REQ-011 SHALL have port grant_valid, output, 1 bit: inner grant valid.
REQ-012 SHALL have port grant_ready, input, 1 bit: inner grant ready.
REQ-013 SHALL have port grant_bits, output, GNT_W bits: the selected grant message.
REQ-014 SHALL have port grant_src, output, clog2(N_REQ) bits: the index of the selected tracker.
REQ-015 SHALL have port lock_active, output, 1 bit: a multi-beat grant is in progress.
REQ-016 SHALL have port beat_cnt, output, clog2(BEATS) bits (min 1): the index of the next beat of the locked grant.

Function
REQ-017 SHALL implement two states: IDLE (arbitrating) and LOCKED (owner streaming beats).
REQ-018 In IDLE, SHALL select the first asserted req_valid in round-robin order starting at (last_win+1) mod N_REQ.
REQ-019 In LOCKED, SHALL select only the owner; req_valid of all other trackers SHALL be ignored.
REQ-020 SHALL drive grant_valid = req_valid[sel], grant_bits = req_bits slice of sel, and grant_src = sel; when no tracker is selected, grant_valid=0, grant_bits=0, grant_src=0.
REQ-021 SHALL drive req_ready[i] = grant_ready && grant_valid && (sel==i); all other req_ready bits SHALL be 0.
REQ-022 grant_valid SHALL NOT depend combinationally on grant_ready.
REQ-023 SHALL define fire = grant_valid && grant_ready; the arbiter adds zero latency (a combinational pass-through).
REQ-024 IDLE fire with req_has_data[sel]=1 and BEATS>1 SHALL transition to LOCKED with owner=sel, beat_cnt=1, last_win=sel.
REQ-025 IDLE fire without data, or with BEATS==1, SHALL remain in IDLE with last_win=sel.
REQ-026 Each LOCKED fire SHALL increment beat_cnt.
REQ-027 The LOCKED fire at beat_cnt==BEATS-1 SHALL return to IDLE with beat_cnt wrapping to 0.
REQ-028 In LOCKED, owner req_valid=0 SHALL produce a bubble (grant_valid=0) while the state, owner and beat_cnt are held.
REQ-029 In IDLE, req_has_data of non-selected trackers SHALL have no effect.
REQ-030 SHALL drive lock_active = (state==LOCKED).

Reset
REQ-031 On assertion of reset_n=0, SHALL immediately force state=IDLE, beat_cnt=0, owner=0, last_win=N_REQ-1, and lock_active=0, regardless of clk.
REQ-032 Reset asserted mid-message SHALL abandon the partial grant; the first arbitration after deassertion SHALL favour tracker 0.
REQ-033 All outputs SHALL be 0 during reset while req_valid=0.

Verification
REQ-034 Reset, then req_valid=4'b1111, all has_data=0, grant_ready=1 -> grant_src sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 Tracker 2 with has_data=1 wins, tracker 1 valid throughout, grant_ready=1 -> four consecutive fires from src 2 with beat_cnt 0,1,2,3, then src 1.
REQ-036 LOCKED on tracker 3 at beat_cnt=2, grant_ready=0 for 3 cycles -> grant_valid=1, bits stable, beat_cnt=2, and req_ready=0 for those cycles.
REQ-037 LOCKED on tracker 0, req_valid[0] dropped 2 cycles while tracker 1 is valid -> grant_valid=0, req_ready[1]=0, and lock_active=1 held.
REQ-038 reset_n pulsed low between clock edges at beat_cnt=1 -> lock_active=0 and beat_cnt=0 immediately; with req_valid=4'b0110 the next winner is 1.
REQ-039 BEATS=1 build with has_data=1 on all trackers -> lock_active stays 0 and round-robin is identical to REQ-034.
